read_memory: RTL
================

READ_MEMORY -- requirements
Module: read_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 40, meaning word width in bits.
REQ-002 SHALL have parameter DEPTH, default 12, meaning number of stored words.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  load strobe for one word.
REQ-006 SHALL have port wr_addr  input  4  load address.
REQ-007 SHALL have port wr_data  input  DATA_W  load data.
REQ-008 SHALL have port start  input  1  single-cycle request to begin streaming.
REQ-009 SHALL have port len  input  4  number of words to stream, sampled with start.
REQ-010 SHALL have port out_data  output  DATA_W  current streamed word.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts word.
REQ-013 SHALL have port out_last  output  1  current word is final word of stream.
REQ-014 SHALL have port busy  output  1  high in STREAM and DONE.
REQ-015 SHALL have port done  output  1  one-cycle pulse after final transfer.
REQ-016 SHALL have port err  output  1  one-cycle pulse on rejected start.

Function
REQ-017 SHALL implement FSM states IDLE, STREAM, DONE.
REQ-018 IDLE: wr_en with wr_addr < DEPTH SHALL write wr_data to mem[wr_addr] at the edge; wr_addr >= DEPTH SHALL be dropped.
REQ-019 wr_en outside IDLE SHALL be dropped; memory contents unchanged.
REQ-020 IDLE + start + 1 <= len <= DEPTH SHALL latch len, clear rd_ptr to 0, enter STREAM next cycle.
REQ-021 IDLE + start + (len == 0 or len > DEPTH) SHALL pulse err next cycle and remain in IDLE.
REQ-022 wr_en and start in the same IDLE cycle: write SHALL occur first, so word 0 of the stream reflects the write if wr_addr == 0.
REQ-023 STREAM: out_valid SHALL be 1; out_data SHALL equal mem[rd_ptr]; out_last SHALL be 1 iff rd_ptr == len_latched - 1.
REQ-024 Transfer SHALL occur on a cycle with out_valid && out_ready; rd_ptr SHALL increment by 1 per transfer.
REQ-025 With out_ready low, out_data, out_last and rd_ptr SHALL hold stable.
REQ-026 Transfer with out_last SHALL move to DONE; out_valid SHALL be 0 from the next cycle.
REQ-027 DONE SHALL last exactly one cycle with done = 1, then return to IDLE.
REQ-028 start in STREAM or DONE SHALL be ignored (no err).
REQ-029 Throughput SHALL be one word per cycle with out_ready held high; first word valid one cycle after accepted start.
REQ-030 rd_ptr SHALL never address beyond DEPTH - 1.

Reset
REQ-031 Assertion of reset SHALL immediately force IDLE, rd_ptr = 0, len_latched = 0, all memory words = 0.
REQ-032 Reset outputs SHALL be: out_valid 0, out_last 0, out_data 0, busy 0, done 0, err 0.
REQ-033 Reset mid-stream SHALL abort with no done pulse; the first edge after release SHALL see IDLE.

Structure
REQ-034 Package read_memory_pkg SHALL hold DATA_W, DEPTH, ADDR_W = 4 and the FSM state enum.
REQ-035 Storage SHALL be one sub-module read_memory_regfile (1 write port, 1 async read port, async-reset registers); FSM/pointers in the top.

Verification
REQ-036 Load mem[0..3] = 40'h1, 40'h2, 40'h3, 40'h4; start, len = 4, out_ready = 1 -> four beats 1,2,3,4 on consecutive cycles, out_last on beat 4, done one cycle later.
REQ-037 Same load; out_ready low 3 cycles during beat 2 -> out_data holds 40'h2, no skip or duplication.
REQ-038 start with len = 0 and, separately, len = 13 -> err pulses one cycle each, out_valid stays 0, busy stays 0.
REQ-039 Full stream len = 12 after loading mem[i] = i + 40'hA0 -> values A0..AB in order, last on AB, rd_ptr never exceeds 11.
REQ-040 wr_en to addr 1 with data 40'hFF during STREAM -> dropped; re-stream returns original mem[1].
REQ-041 Assert reset at beat 2 of a len = 4 stream -> out_valid 0 immediately, no done; fresh stream of len = 1 after release returns 40'h0.

Source files
------------

// File: rtl/read_memory_pkg.sv
// rtl/read_memory_pkg.sv - shared widths, depth and FSM state type for read_memory
package read_memory_pkg;

    localparam int DATA_W = 40;
    localparam int DEPTH  = 12;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/read_memory_if.sv
// rtl/read_memory_if.sv - load, start and output stream signals of read_memory
interface read_memory_if
    #(parameter int DATA_W = read_memory_pkg::DATA_W);

    import read_memory_pkg::*;

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                start;
    logic [ADDR_W-1:0]   len;
    logic [DATA_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output wr_en, wr_addr, wr_data, start, len, out_ready,
        input  out_data, out_valid, out_last, busy, done, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, len, out_ready,
        output out_data, out_valid, out_last, busy, done, err
    );

endinterface

// File: rtl/read_memory_regfile.sv
// rtl/read_memory_regfile.sv - word storage, one write port and one asynchronous read port
module read_memory_regfile #(
    parameter int DATA_W = 40,
    parameter int DEPTH  = 12,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage array; reset clears every word, out-of-range writes are ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr < ADDR_W'(DEPTH))) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Out-of-range reads return zero rather than indexing past the array
    assign o_rd_data = (i_rd_addr < ADDR_W'(DEPTH)) ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/read_memory.sv
// rtl/read_memory.sv - loadable word store that streams its first len words on request
module read_memory #(
    parameter int DATA_W = read_memory_pkg::DATA_W,
    parameter int DEPTH  = read_memory_pkg::DEPTH
) (
    input logic          clk,
    input logic          reset,
    read_memory_if.slave bus
);

    import read_memory_pkg::*;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_len;
    logic              r_err;

    logic [DATA_W-1:0] w_rd_data;
    logic              w_wr_en;
    logic              w_len_ok;
    logic              w_accept;
    logic              w_reject;
    logic              w_xfer;
    logic              w_last;

    assign w_len_ok = (bus.len != '0) && (bus.len <= ADDR_W'(DEPTH));
    assign w_last   = (r_state == S_STREAM) && (r_rd_ptr == (r_len - ADDR_W'(1)));

    // Next-state, per-cycle strobes and stream outputs derived from the current state
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_en       = 1'b0;
        w_accept      = 1'b0;
        w_reject      = 1'b0;
        w_xfer        = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = '0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.err       = r_err;
        case (r_state)
            S_IDLE: begin
                w_wr_en = bus.wr_en && (bus.wr_addr < ADDR_W'(DEPTH));
                if (bus.start) begin
                    if (w_len_ok) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_STREAM;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                bus.out_valid = 1'b1;
                bus.out_last  = w_last;
                bus.out_data  = w_rd_data;
                bus.busy      = 1'b1;
                w_xfer        = bus.out_ready;
                if (w_xfer && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.busy    = 1'b1;
                bus.done    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read pointer, latched length and the rejected-start pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_len    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_accept) begin
                r_len    <= bus.len;
                r_rd_ptr <= '0;
            end else if (w_xfer) begin
                // Wrap to zero on the final word so the pointer never leaves the array
                if (w_last) begin
                    r_rd_ptr <= '0;
                end else begin
                    r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                end
            end
        end
    end

    read_memory_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

endmodule
